// File: rtl/xlu_muldiv.sv
// ---------------------------------------------------------------------------
// xlu_muldiv
//   Multiply/divide unit with architectural HI/LO registers for the E stage
//   of the pipelined MIPS core. It executes mult, multu, div, divu, mthi,
//   mtlo, mfhi and mflo. Multiplies and divides take a configurable number of
//   cycles, during which busy is held so the hazard unit can stall dependent
//   instructions. The result is computed at accept time, parked in a pending
//   register, and committed to HI/LO when the latency counter expires.
//
// Parameters
//   WIDTH        operand and HI/LO width
//   MULT_CYCLES  mult/multu latency in cycles (>= 1)
//   DIV_CYCLES   div/divu latency in cycles (>= 1)
//
// Ports
//   clk      in   system clock, rising edge
//   rst_n    in   asynchronous active-low reset
//   start    in   E-stage instruction valid
//   xlu_op   in   operation code (1000 or any unlisted value = none)
//   flush    in   cancels the E-stage instruction this cycle
//   src_a    in   rs operand
//   src_b    in   rt operand
//   busy     out  multiply/divide in flight (registered)
//   done     out  one-cycle pulse in the final busy cycle (registered)
//   hi       out  architectural HI
//   lo       out  architectural LO
//   rd_data  out  mfhi/mflo read value (combinational)
// ---------------------------------------------------------------------------
module xlu_muldiv #(
  parameter int WIDTH       = 32,
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [3:0]       xlu_op,
  input  logic             flush,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic [WIDTH-1:0] rd_data
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  // A one-bit counter is kept even when both latencies are 1 so the
  // register never collapses to zero width.
  localparam int CNT_W = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;
  localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES - 1);
  localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES - 1);
  localparam logic [WIDTH-1:0] MIN_VAL   = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [3:0] {
    OP_MULT  = 4'b0000,
    OP_MULTU = 4'b0001,
    OP_DIV   = 4'b0010,
    OP_DIVU  = 4'b0011,
    OP_MTHI  = 4'b0100,
    OP_MTLO  = 4'b0101,
    OP_MFHI  = 4'b0110,
    OP_MFLO  = 4'b0111
  } xluOp_t;

  typedef enum logic {
    ST_IDLE,
    ST_RUN
  } state_t;

  state_t             r_state;
  state_t             w_nextState;
  logic [CNT_W-1:0]   r_count;
  logic [2*WIDTH-1:0] r_pending;
  logic [WIDTH-1:0]   r_hi;
  logic [WIDTH-1:0]   r_lo;
  logic               r_done;

  logic               w_accept;
  logic               w_isMult;
  logic               w_isDiv;
  logic               w_startArith;
  logic               w_commit;
  logic [CNT_W-1:0]   w_loadVal;

  logic [2*WIDTH-1:0] w_prodS;
  logic [2*WIDTH-1:0] w_prodU;
  logic               w_negA;
  logic               w_negB;
  logic [WIDTH-1:0]   w_divA;
  logic [WIDTH-1:0]   w_divB;
  logic [WIDTH-1:0]   w_uq;
  logic [WIDTH-1:0]   w_ur;
  logic [WIDTH-1:0]   w_quot;
  logic [WIDTH-1:0]   w_rem;
  logic               w_overflow;
  logic [2*WIDTH-1:0] w_result;

  // Only an idle unit accepts; a flushed instruction never starts anything.
  assign w_accept     = start & ~flush & ~busy;
  assign w_isMult     = (xlu_op == OP_MULT) || (xlu_op == OP_MULTU);
  assign w_isDiv      = (xlu_op == OP_DIV)  || (xlu_op == OP_DIVU);
  assign w_startArith = w_accept & (w_isMult | w_isDiv);
  assign w_loadVal    = w_isMult ? MULT_LOAD : DIV_LOAD;

  // Full-width products, operands sign- or zero-extended to 2*WIDTH first.
  assign w_prodS = $signed({{WIDTH{src_a[WIDTH-1]}}, src_a}) *
                   $signed({{WIDTH{src_b[WIDTH-1]}}, src_b});
  assign w_prodU = {{WIDTH{1'b0}}, src_a} * {{WIDTH{1'b0}}, src_b};

  // Signed divide runs on magnitudes; the quotient is negated when the
  // operand signs differ and the remainder follows the dividend's sign,
  // which gives truncation toward zero.
  assign w_negA     = (xlu_op == OP_DIV) & src_a[WIDTH-1];
  assign w_negB     = (xlu_op == OP_DIV) & src_b[WIDTH-1];
  assign w_divA     = w_negA ? -src_a : src_a;
  assign w_divB     = w_negB ? -src_b : src_b;
  assign w_uq       = w_divA / w_divB;
  assign w_ur       = w_divA % w_divB;
  assign w_quot     = (w_negA ^ w_negB) ? -w_uq : w_uq;
  assign w_rem      = w_negA ? -w_ur : w_ur;
  assign w_overflow = (xlu_op == OP_DIV) && (src_a == MIN_VAL) && (src_b == {WIDTH{1'b1}});

  // Pending {HI,LO} value for the operation being accepted this cycle.
  always_comb begin
    w_result = '0;
    case (xlu_op)
      OP_MULT:  w_result = w_prodS;
      OP_MULTU: w_result = w_prodU;
      OP_DIV, OP_DIVU: begin
        if (src_b == '0) begin
          w_result = {src_a, {WIDTH{1'b1}}};
        end else if (w_overflow) begin
          w_result = {{WIDTH{1'b0}}, MIN_VAL};
        end else begin
          w_result = {w_rem, w_quot};
        end
      end
      default: w_result = '0;
    endcase
  end

  // State register: RUN is exactly the busy interval.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next state; commit happens on the edge that ends the last busy cycle.
  always_comb begin
    w_nextState = r_state;
    w_commit    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_startArith) begin
          w_nextState = ST_RUN;
        end
      end
      ST_RUN: begin
        if (r_count == '0) begin
          w_nextState = ST_IDLE;
          w_commit    = 1'b1;
        end
      end
      default: w_nextState = ST_IDLE;
    endcase
  end

  // Datapath registers. done is raised one edge ahead of the commit so it
  // lands in the final busy cycle; with a latency of 1 that means at accept.
  // mthi/mtlo can only be accepted while idle, so they never race a commit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count   <= '0;
      r_pending <= '0;
      r_hi      <= '0;
      r_lo      <= '0;
      r_done    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (w_startArith) begin
        r_pending <= w_result;
        r_count   <= w_loadVal;
        r_done    <= (w_loadVal == '0);
      end else if (r_state == ST_RUN) begin
        if (w_commit) begin
          r_hi <= r_pending[2*WIDTH-1:WIDTH];
          r_lo <= r_pending[WIDTH-1:0];
        end else begin
          r_count <= r_count - CNT_W'(1);
          r_done  <= (r_count == CNT_W'(1));
        end
      end
      if (w_accept && (xlu_op == OP_MTHI)) begin
        r_hi <= src_a;
      end
      if (w_accept && (xlu_op == OP_MTLO)) begin
        r_lo <= src_a;
      end
    end
  end

  // Register reads bypass start: the value tracks HI/LO and the opcode only.
  always_comb begin
    rd_data = '0;
    case (xlu_op)
      OP_MFHI: rd_data = r_hi;
      OP_MFLO: rd_data = r_lo;
      default: rd_data = '0;
    endcase
  end

  assign busy = (r_state == ST_RUN);
  assign done = r_done;
  assign hi   = r_hi;
  assign lo   = r_lo;

endmodule

// File: tb/tb_xlu_muldiv.sv
// ---------------------------------------------------------------------------
// tb_xlu_muldiv
//   Self-checking bench for xlu_muldiv with default parameters. Expected
//   {HI,LO} values are queued when an operation is issued and popped when the
//   unit reports completion.
// ---------------------------------------------------------------------------
module tb_xlu_muldiv;

  localparam int W     = 32;
  localparam int NMULT = 5;
  localparam int NDIV  = 10;

  localparam logic [3:0] OP_MULT  = 4'b0000;
  localparam logic [3:0] OP_MULTU = 4'b0001;
  localparam logic [3:0] OP_DIV   = 4'b0010;
  localparam logic [3:0] OP_DIVU  = 4'b0011;
  localparam logic [3:0] OP_MTHI  = 4'b0100;
  localparam logic [3:0] OP_MTLO  = 4'b0101;
  localparam logic [3:0] OP_MFHI  = 4'b0110;
  localparam logic [3:0] OP_MFLO  = 4'b0111;
  localparam logic [3:0] OP_NONE  = 4'b1000;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [3:0]   xlu_op;
  logic         flush;
  logic [W-1:0] src_a;
  logic [W-1:0] src_b;
  logic         busy;
  logic         done;
  logic [W-1:0] hi;
  logic [W-1:0] lo;
  logic [W-1:0] rd_data;

  int           nCompared   = 0;
  int           nMismatched = 0;
  logic [63:0]  expQ[$];
  logic [W-1:0] expHi;
  logic [W-1:0] expLo;

  xlu_muldiv #(
    .WIDTH      (W),
    .MULT_CYCLES(NMULT),
    .DIV_CYCLES (NDIV)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .xlu_op (xlu_op),
    .flush  (flush),
    .src_a  (src_a),
    .src_b  (src_b),
    .busy   (busy),
    .done   (done),
    .hi     (hi),
    .lo     (lo),
    .rd_data(rd_data)
  );

  always #5 clk = ~clk;

  // Reference model of {HI,LO} for the arithmetic opcodes.
  function automatic logic [63:0] modelResult(input logic [3:0] op,
                                              input logic [31:0] a,
                                              input logic [31:0] b);
    longint sa, sb, sp, sq, sr;
    logic [63:0] r;
    sa = $signed(a);
    sb = $signed(b);
    r  = '0;
    case (op)
      OP_MULT:  begin sp = sa * sb; r = sp; end
      OP_MULTU: r = {32'h0, a} * {32'h0, b};
      OP_DIV: begin
        if (b == 0) r = {a, 32'hFFFFFFFF};
        else begin
          sq = sa / sb;
          sr = sa % sb;
          r  = {sr[31:0], sq[31:0]};
        end
      end
      OP_DIVU: begin
        if (b == 0) r = {a, 32'hFFFFFFFF};
        else r = {a % b, a / b};
      end
      default: r = '0;
    endcase
    return r;
  endfunction

  // Drives one instruction for a single accept edge, then returns to idle.
  task automatic applyStimulus(input logic [3:0] op, input logic [31:0] a,
                               input logic [31:0] b, input logic fl);
    start  = 1'b1;
    xlu_op = op;
    src_a  = a;
    src_b  = b;
    flush  = fl;
    @(posedge clk);
    #1;
    start  = 1'b0;
    flush  = 1'b0;
    xlu_op = OP_NONE;
  endtask

  // Counts busy cycles and done pulses until busy drops (bounded).
  task automatic waitForDone(output int busyCnt, output int doneAt,
                             output int doneCnt, output bit timedOut);
    busyCnt  = 0;
    doneAt   = 0;
    doneCnt  = 0;
    timedOut = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (busy) begin
        busyCnt++;
        if (done) begin
          doneCnt++;
          doneAt = busyCnt;
        end
      end else begin
        if (done) doneCnt++;
        timedOut = 1'b0;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst_n  = 1'b0;
    start  = 1'b0;
    flush  = 1'b0;
    xlu_op = OP_MFHI;
    src_a  = '0;
    src_b  = '0;
    repeat (2) @(negedge clk);
    nCompared++; if (busy !== 1'b0) begin nMismatched++; $display("[TB] FAIL reset busy: got %b want 0", busy); end
    nCompared++; if (done !== 1'b0) begin nMismatched++; $display("[TB] FAIL reset done: got %b want 0", done); end
    nCompared++; if (hi !== '0) begin nMismatched++; $display("[TB] FAIL reset hi: got %h want 0", hi); end
    nCompared++; if (lo !== '0) begin nMismatched++; $display("[TB] FAIL reset lo: got %h want 0", lo); end
    nCompared++; if (rd_data !== '0) begin nMismatched++; $display("[TB] FAIL reset rd_data: got %h want 0", rd_data); end
    expHi  = '0;
    expLo  = '0;
    xlu_op = OP_NONE;
    rst_n  = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_mult();
    logic [3:0]  ops[6];
    logic [31:0] as[6];
    logic [31:0] bs[6];
    logic [63:0] e;
    int bc, da, dc;
    bit to;
    ops = '{OP_MULT, OP_MULTU, OP_MULT, OP_MULTU, OP_MULT, OP_MULTU};
    as  = '{32'hFFFFFFFD, 32'hFFFFFFFF, 32'h80000000, 32'h0001_0000, $urandom, $urandom};
    bs  = '{32'h00000005, 32'hFFFFFFFF, 32'h80000000, 32'h0001_0000, $urandom, $urandom};
    for (int i = 0; i < 6; i++) begin
      expQ.push_back(modelResult(ops[i], as[i], bs[i]));
      applyStimulus(ops[i], as[i], bs[i], 1'b0);
      waitForDone(bc, da, dc, to);
      e = expQ.pop_front();
      expHi = e[63:32];
      expLo = e[31:0];
      nCompared++; if (to || bc != NMULT) begin nMismatched++; $display("[TB] FAIL mult[%0d] busy cycles: got %0d want %0d (timeout=%0d)", i, bc, NMULT, to); end
      nCompared++; if (dc != 1 || da != NMULT) begin nMismatched++; $display("[TB] FAIL mult[%0d] done pulse: count %0d at %0d, want 1 at %0d", i, dc, da, NMULT); end
      nCompared++; if ({hi, lo} !== e) begin nMismatched++; $display("[TB] FAIL mult[%0d] hi/lo: got %h_%h want %h_%h", i, hi, lo, e[63:32], e[31:0]); end
      if (i == 0) begin
        nCompared++; if (hi !== 32'hFFFFFFFF || lo !== 32'hFFFFFFF1) begin nMismatched++; $display("[TB] FAIL mult -3*5: got %h_%h want FFFFFFFF_FFFFFFF1", hi, lo); end
      end
    end
  endtask

  task automatic test_div();
    logic [3:0]  ops[6];
    logic [31:0] as[6];
    logic [31:0] bs[6];
    logic [63:0] e;
    int bc, da, dc;
    bit to;
    ops = '{OP_DIVU, OP_DIV, OP_DIV, OP_DIV, OP_DIV, OP_DIVU};
    as  = '{32'd7, 32'hFFFFFFF9, 32'd100, 32'hFFFFFF9C, $urandom, $urandom};
    bs  = '{32'd2, 32'd2, 32'hFFFFFFF9, 32'hFFFFFFF9, $urandom_range(1, 1000), $urandom_range(1, 65535)};
    for (int i = 0; i < 6; i++) begin
      expQ.push_back(modelResult(ops[i], as[i], bs[i]));
      applyStimulus(ops[i], as[i], bs[i], 1'b0);
      waitForDone(bc, da, dc, to);
      e = expQ.pop_front();
      expHi = e[63:32];
      expLo = e[31:0];
      nCompared++; if (to || bc != NDIV) begin nMismatched++; $display("[TB] FAIL div[%0d] busy cycles: got %0d want %0d (timeout=%0d)", i, bc, NDIV, to); end
      nCompared++; if (dc != 1 || da != NDIV) begin nMismatched++; $display("[TB] FAIL div[%0d] done pulse: count %0d at %0d, want 1 at %0d", i, dc, da, NDIV); end
      nCompared++; if ({hi, lo} !== e) begin nMismatched++; $display("[TB] FAIL div[%0d] hi/lo: got %h_%h want %h_%h", i, hi, lo, e[63:32], e[31:0]); end
    end
  endtask

  task automatic test_div_edges();
    logic [3:0]  ops[4];
    logic [31:0] as[4];
    logic [31:0] bs[4];
    logic [31:0] wantHi[4];
    logic [31:0] wantLo[4];
    logic [63:0] e;
    int bc, da, dc;
    bit to;
    ops    = '{OP_DIV, OP_DIVU, OP_DIV, OP_DIV};
    as     = '{32'h80000000, 32'h00001234, 32'hFFFFFF00, 32'h80000000};
    bs     = '{32'hFFFFFFFF, 32'h00000000, 32'h00000000, 32'h00000001};
    wantHi = '{32'h00000000, 32'h00001234, 32'hFFFFFF00, 32'h00000000};
    wantLo = '{32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h80000000};
    for (int i = 0; i < 4; i++) begin
      expQ.push_back({wantHi[i], wantLo[i]});
      applyStimulus(ops[i], as[i], bs[i], 1'b0);
      waitForDone(bc, da, dc, to);
      e = expQ.pop_front();
      expHi = e[63:32];
      expLo = e[31:0];
      nCompared++; if (to || bc != NDIV) begin nMismatched++; $display("[TB] FAIL divedge[%0d] busy cycles: got %0d want %0d (timeout=%0d)", i, bc, NDIV, to); end
      nCompared++; if ({hi, lo} !== e) begin nMismatched++; $display("[TB] FAIL divedge[%0d] hi/lo: got %h_%h want %h_%h", i, hi, lo, e[63:32], e[31:0]); end
    end
  endtask

  task automatic test_flush();
    applyStimulus(OP_MULT, 32'd7, 32'd9, 1'b1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      nCompared++; if (busy !== 1'b0) begin nMismatched++; $display("[TB] FAIL flush busy cycle %0d: got %b want 0", i, busy); end
    end
    nCompared++; if (hi !== expHi || lo !== expLo) begin nMismatched++; $display("[TB] FAIL flush mult hi/lo: got %h_%h want %h_%h", hi, lo, expHi, expLo); end
    applyStimulus(OP_MTHI, 32'h5555AAAA, 32'd0, 1'b1);
    applyStimulus(OP_MTLO, 32'hAAAA5555, 32'd0, 1'b1);
    @(negedge clk);
    nCompared++; if (hi !== expHi || lo !== expLo) begin nMismatched++; $display("[TB] FAIL flush mt hi/lo: got %h_%h want %h_%h", hi, lo, expHi, expLo); end
  endtask

  task automatic test_start_while_busy();
    logic [63:0] e;
    int bc, da, dc;
    bit to;
    expQ.push_back(modelResult(OP_MULT, 32'hFFFF0001, 32'h00000123));
    applyStimulus(OP_MULT, 32'hFFFF0001, 32'h00000123, 1'b0);
    start  = 1'b1;
    xlu_op = OP_MULT;
    src_a  = 32'd2;
    src_b  = 32'd3;
    @(posedge clk);
    #1;
    xlu_op = OP_MTHI;
    src_a  = 32'h0BAD0BAD;
    @(posedge clk);
    #1;
    start  = 1'b0;
    xlu_op = OP_NONE;
    waitForDone(bc, da, dc, to);
    e = expQ.pop_front();
    expHi = e[63:32];
    expLo = e[31:0];
    nCompared++; if (to || bc != NMULT - 2) begin nMismatched++; $display("[TB] FAIL busy-ignore remaining busy: got %0d want %0d (timeout=%0d)", bc, NMULT - 2, to); end
    nCompared++; if ({hi, lo} !== e) begin nMismatched++; $display("[TB] FAIL busy-ignore hi/lo: got %h_%h want %h_%h", hi, lo, e[63:32], e[31:0]); end
    @(negedge clk);
    nCompared++; if (busy !== 1'b0) begin nMismatched++; $display("[TB] FAIL busy-ignore restart: got busy %b want 0", busy); end
  endtask

  task automatic test_move();
    applyStimulus(OP_MTHI, 32'hDEADBEEF, 32'd0, 1'b0);
    expHi  = 32'hDEADBEEF;
    xlu_op = OP_MFHI;
    #1;
    nCompared++; if (hi !== 32'hDEADBEEF) begin nMismatched++; $display("[TB] FAIL mthi hi: got %h want DEADBEEF", hi); end
    nCompared++; if (rd_data !== 32'hDEADBEEF) begin nMismatched++; $display("[TB] FAIL mfhi rd_data: got %h want DEADBEEF", rd_data); end
    nCompared++; if (busy !== 1'b0) begin nMismatched++; $display("[TB] FAIL mthi busy: got %b want 0", busy); end
    xlu_op = OP_MFLO;
    #1;
    nCompared++; if (rd_data !== expLo) begin nMismatched++; $display("[TB] FAIL mflo prior lo: got %h want %h", rd_data, expLo); end
    @(negedge clk);
    applyStimulus(OP_MTLO, 32'h12345678, 32'd0, 1'b0);
    expLo  = 32'h12345678;
    xlu_op = OP_MFLO;
    #1;
    nCompared++; if (lo !== 32'h12345678 || rd_data !== 32'h12345678) begin nMismatched++; $display("[TB] FAIL mtlo: lo %h rd_data %h want 12345678", lo, rd_data); end
    nCompared++; if (hi !== expHi) begin nMismatched++; $display("[TB] FAIL mtlo kept hi: got %h want %h", hi, expHi); end
    xlu_op = OP_NONE;
    #1;
    nCompared++; if (rd_data !== '0) begin nMismatched++; $display("[TB] FAIL rd_data none: got %h want 0", rd_data); end
    xlu_op = 4'hF;
    #1;
    nCompared++; if (rd_data !== '0) begin nMismatched++; $display("[TB] FAIL rd_data op F: got %h want 0", rd_data); end
    xlu_op = OP_NONE;
    @(negedge clk);
  endtask

  task automatic test_reset_mid_op();
    logic [63:0] e;
    int bc, da, dc;
    bit to;
    applyStimulus(OP_DIV, 32'd100, 32'd7, 1'b0);
    repeat (3) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    nCompared++; if (busy !== 1'b0 || done !== 1'b0) begin nMismatched++; $display("[TB] FAIL reset mid-op busy/done: got %b/%b want 0/0", busy, done); end
    nCompared++; if (hi !== '0 || lo !== '0) begin nMismatched++; $display("[TB] FAIL reset mid-op hi/lo: got %h_%h want 0_0", hi, lo); end
    expHi = '0;
    expLo = '0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    nCompared++; if (busy !== 1'b0 || hi !== '0 || lo !== '0) begin nMismatched++; $display("[TB] FAIL after reset: busy %b hi %h lo %h want 0", busy, hi, lo); end
    expQ.push_back(modelResult(OP_MULTU, 32'd3, 32'd4));
    applyStimulus(OP_MULTU, 32'd3, 32'd4, 1'b0);
    waitForDone(bc, da, dc, to);
    e = expQ.pop_front();
    expHi = e[63:32];
    expLo = e[31:0];
    nCompared++; if (to || bc != NMULT) begin nMismatched++; $display("[TB] FAIL post-reset multu busy: got %0d want %0d (timeout=%0d)", bc, NMULT, to); end
    nCompared++; if (hi !== 32'h0 || lo !== 32'hC) begin nMismatched++; $display("[TB] FAIL post-reset multu: got %h_%h want 00000000_0000000C", hi, lo); end
  endtask

  task automatic test_back_to_back();
    logic [3:0]  ops[4];
    logic [31:0] as[4];
    logic [31:0] bs[4];
    logic [63:0] e;
    int bc, da, dc;
    bit to;
    ops = '{OP_MULT, OP_DIV, OP_MULTU, OP_DIVU};
    as  = '{$urandom, $urandom, $urandom, $urandom};
    bs  = '{$urandom, $urandom_range(1, 50), $urandom, $urandom_range(1, 50)};
    for (int i = 0; i < 4; i++) begin
      expQ.push_back(modelResult(ops[i], as[i], bs[i]));
      applyStimulus(ops[i], as[i], bs[i], 1'b0);
      waitForDone(bc, da, dc, to);
      e = expQ.pop_front();
      expHi = e[63:32];
      expLo = e[31:0];
      nCompared++; if (to || bc != (i % 2 == 0 ? NMULT : NDIV)) begin nMismatched++; $display("[TB] FAIL b2b[%0d] busy cycles: got %0d (timeout=%0d)", i, bc, to); end
      nCompared++; if ({hi, lo} !== e) begin nMismatched++; $display("[TB] FAIL b2b[%0d] hi/lo: got %h_%h want %h_%h", i, hi, lo, e[63:32], e[31:0]); end
    end
  endtask

  initial begin
    test_reset();
    test_mult();
    test_div();
    test_div_edges();
    test_flush();
    test_start_while_busy();
    test_move();
    test_reset_mid_op();
    test_back_to_back();
    nCompared++; if (expQ.size() != 0) begin nMismatched++; $display("[TB] FAIL scoreboard leftovers: got %0d want 0", expQ.size()); end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

  // Global time bound so a stuck run still terminates.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/xlu_muldiv.md
# xlu_muldiv

Parametrised multiply/divide unit with HI/LO registers for the E stage of the pipelined MIPS core. It executes the `xlu_op` class decoded by the E-stage controller: mult, multu, div, divu, mthi, mtlo, mfhi and mflo. Operation latency is configurable, and the unit drives a `busy` flag that the hazard unit uses to stall dependent instructions. It adds an exception flush input, so a cancelled instruction never starts an operation or writes HI/LO.

## Interface
- `WIDTH`, 32: operand width and HI/LO width.
- `MULT_CYCLES`, 5: mult/multu latency in cycles; must be ≥1.
- `DIV_CYCLES`, 10: div/divu latency in cycles; must be ≥1.
- `clk`  in  1  system clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  E-stage instruction valid (not bubble, not stalled).
- `xlu_op`  in  4  opcodes:
  - 0000 mult, 0001 multu, 0010 div, 0011 divu
  - 0100 mthi, 0101 mtlo, 0110 mfhi, 0111 mflo
  - 1000 none; any other value is treated as none.
- `flush`  in  1  exception/eret flush of the E-stage instruction this cycle.
- `src_a`  in  WIDTH  rs operand (forwarded).
- `src_b`  in  WIDTH  rt operand (forwarded).
- `busy`  out  1  operation in flight.
- `done`  out  1  one-cycle pulse in the final busy cycle.
- `hi`  out  WIDTH  architectural HI.
- `lo`  out  WIDTH  architectural LO.
- `rd_data`  out  WIDTH  mfhi/mflo read value.

## Operation
- Accept condition: `accept = start & ~flush & ~busy`.
- Reset: HI=0, LO=0, busy=0, done=0, counter=0, pending result=0.
- On accept with mult/multu/div/divu:
  - Compute the 2·WIDTH pending result from `src_a`/`src_b` and latch it.
  - Load the counter with N−1, where N is `MULT_CYCLES` or `DIV_CYCLES`.
  - Set busy.
- Busy cycles: the counter decrements each cycle. When it reaches 0 and busy=1:
  - Commit the pending result to HI/LO.
  - Clear busy.
  - Pulse done.
- Arithmetic results:
  - mult: signed WIDTH×WIDTH → {HI,LO}.
  - multu: unsigned WIDTH×WIDTH → {HI,LO}.
  - div: LO = quotient truncated toward zero; HI = remainder, taking the sign of the dividend.
  - divu: unsigned quotient and remainder.
- Divide-by-zero (div and divu): LO = all ones; HI = src_a.
- Signed overflow (div of MIN by −1): LO = MIN; HI = 0.
- mthi/mtlo on accept: write `src_a` to HI/LO at that edge. No busy.
- `rd_data`: combinational. Equals HI when xlu_op=0110, LO when 0111, otherwise 0. It reflects the current registers regardless of `start`.
- `start` while busy: ignored, including mt writes. The hazard unit stalls any xlu instruction while `busy | (start & xlu_op is mult/div)`; violating that rule loses the instruction.
- `flush` gates only the same-cycle accept. An operation already in flight completes and commits (it belongs to an older, committed instruction).
- Reset mid-operation: everything returns to reset values immediately, and the pending result is discarded.

## Timing
- Accept at edge E0 → busy=1 for exactly N cycles after E0.
- done=1 in the last of those N cycles; HI/LO show the result from edge E0+N onward.
- `busy` and `done` are registered outputs; `rd_data` is combinational from HI/LO and `xlu_op`.
- Back-to-back: a new mult/div is accepted in the first cycle with busy=0, i.e. the cycle after done. No overlap.
- mthi/mtlo: value visible on `hi`/`lo` in the cycle after accept.
- Counter width is clog2(max(MULT_CYCLES, DIV_CYCLES)). No wrap: the counter is loaded only on accept.

## Test plan
- Signed multiply, N=5: mult src_a=FFFFFFFD (−3), src_b=5, start=1 → busy high 5 cycles, done in the 5th; HI=FFFFFFFF, LO=FFFFFFF1.
- Signed and unsigned divide, N=10:
  - divu 7/2 → LO=3, HI=1 after 10 cycles.
  - div FFFFFFF9 (−7) / 2 → LO=FFFFFFFD, HI=FFFFFFFF.
- Division edge cases:
  - div 80000000 / FFFFFFFF → LO=80000000, HI=0.
  - divu 1234 / 0 → LO=FFFFFFFF, HI=1234.
- Flush and start-while-busy:
  - mult with start=1, flush=1 → busy stays 0; HI/LO unchanged.
  - A second mult issued while busy → ignored; the first result commits.
- Move to/from HI/LO: mthi src_a=DEADBEEF, then mfhi next cycle → hi=DEADBEEF, rd_data=DEADBEEF; mflo rd_data equals the prior LO.
- Reset mid-operation: rst_n low during cycle 3 of a div → busy=0, done=0, HI=LO=0 asynchronously; after release a new multu 3×4 → LO=C, HI=0.
